// File: rtl/dmm_line_responder.sv
// dmm_line_responder
//   Memory-side responder for the dmm_unit line interface. Accepts one
//   256-bit line read or write at a time, services it from an internal line
//   store mapped at BASE_ADDR, and answers after LATENCY cycles with a
//   single-cycle done pulse (plus err_o for out-of-range addresses).
//
// Ports
//   clk               clock, rising edge
//   rst               asynchronous active-high reset (store is not cleared)
//   dmm_unit_strobe   request valid, sampled only while idle
//   dmm_unit_addr     byte address, bits [4:0] ignored
//   dmm_unit_rw       1 = write, 0 = read
//   dmm_unit_dataout  write data
//   dmm_unit_size     write byte count from byte 0 up; 0 or >= 32 = full line
//   dmm_unit_done     one-cycle completion pulse
//   dmm_unit_datain   read data, held until the next read completes
//   err_o             one-cycle pulse with done for out-of-range requests
module dmm_line_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h70000000,
    parameter int          LINES     = 64,
    parameter int          LATENCY   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         dmm_unit_strobe,
    input  logic [31:0]  dmm_unit_addr,
    input  logic         dmm_unit_rw,
    input  logic [255:0] dmm_unit_dataout,
    input  logic [7:0]   dmm_unit_size,
    output logic         dmm_unit_done,
    output logic [255:0] dmm_unit_datain,
    output logic         err_o
);

    localparam int IDX_W = $clog2(LINES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state_reg;
    logic [3:0]         cnt_reg;
    logic [IDX_W-1:0]   index_reg;
    logic               in_range_reg;
    logic               rw_reg;
    logic [255:0]       wdata_reg;
    logic [7:0]         size_reg;

    // Address decode of the live request (only meaningful while idle).
    logic [31:0]        offset;
    logic               in_range_now;
    logic [IDX_W-1:0]   index_now;
    logic               unused_offset_bits;

    assign offset             = dmm_unit_addr - BASE_ADDR;
    assign in_range_now       = (dmm_unit_addr >= BASE_ADDR) && (offset[31:5] < 27'(LINES));
    assign index_now          = offset[5 +: IDX_W];
    assign unused_offset_bits = ^offset[4:0];

    logic accept;
    logic enter_resp;
    logic commit;
    logic load_read;

    // With LATENCY == 1 the read must be taken on the accepting edge itself,
    // so the store read port uses the live request fields in that case.
    logic               rd_rw;
    logic               rd_in_range;
    logic [IDX_W-1:0]   rd_index;
    logic [5:0]         eff_size;

    assign accept      = (state_reg == IDLE) && dmm_unit_strobe;
    assign enter_resp  = (accept && (LATENCY == 1)) || ((state_reg == WAIT) && (cnt_reg == 4'd0));
    assign rd_rw       = accept ? dmm_unit_rw  : rw_reg;
    assign rd_in_range = accept ? in_range_now : in_range_reg;
    assign rd_index    = accept ? index_now    : index_reg;
    assign load_read   = enter_resp && !rd_rw;

    // Writes commit on the edge that leaves RESP; an async reset during RESP
    // forces IDLE first, so an aborted write never reaches the store.
    assign commit   = (state_reg == RESP) && rw_reg && in_range_reg;
    assign eff_size = ((size_reg == 8'd0) || (size_reg >= 8'd32)) ? 6'd32 : size_reg[5:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            index_reg     <= '0;
            in_range_reg  <= 1'b0;
            rw_reg        <= 1'b0;
            wdata_reg     <= '0;
            size_reg      <= 8'd0;
            dmm_unit_done <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            dmm_unit_done <= 1'b0;
            err_o         <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (dmm_unit_strobe) begin
                        index_reg    <= index_now;
                        in_range_reg <= in_range_now;
                        rw_reg       <= dmm_unit_rw;
                        wdata_reg    <= dmm_unit_dataout;
                        size_reg     <= dmm_unit_size;
                        if (LATENCY == 1) begin
                            state_reg     <= RESP;
                            dmm_unit_done <= 1'b1;
                            err_o         <= !in_range_now;
                        end else begin
                            state_reg <= WAIT;
                            cnt_reg   <= 4'(LATENCY >= 2 ? LATENCY - 2 : 0);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg     <= RESP;
                        dmm_unit_done <= 1'b1;
                        err_o         <= !in_range_reg;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Line store split into 32 byte lanes so byte-enabled writes map onto
    // independent RAMs with a registered read each.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_lane
            logic [7:0] lane_mem [LINES] = '{default: 8'h00};
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (commit && (6'(gi) < eff_size)) begin
                    lane_mem[index_reg] <= wdata_reg[8*gi +: 8];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_byte_reg <= 8'h00;
                end else if (load_read) begin
                    rd_byte_reg <= rd_in_range ? lane_mem[rd_index] : 8'h00;
                end
            end

            assign dmm_unit_datain[8*gi +: 8] = rd_byte_reg;
        end
    endgenerate

endmodule

// File: tb/tb_dmm_line_responder.sv
module tb_dmm_line_responder;

    localparam logic [31:0] BASE  = 32'h70000000;
    localparam int          LINES = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  addr = '0;
    logic         rw = 1'b0;
    logic [255:0] wdata = '0;
    logic [7:0]   size = '0;
    logic         stb0 = 1'b0, stb1 = 1'b0, stb2 = 1'b0;
    logic         done0, done1, done2;
    logic         err0, err1, err2;
    logic [255:0] din0, din1, din2;

    always #5 clk = ~clk;

    dmm_line_responder #(.BASE_ADDR(BASE), .LINES(LINES), .LATENCY(4)) u_dut (
        .clk(clk), .rst(rst), .dmm_unit_strobe(stb0), .dmm_unit_addr(addr),
        .dmm_unit_rw(rw), .dmm_unit_dataout(wdata), .dmm_unit_size(size),
        .dmm_unit_done(done0), .dmm_unit_datain(din0), .err_o(err0));

    dmm_line_responder #(.BASE_ADDR(BASE), .LINES(LINES), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .dmm_unit_strobe(stb1), .dmm_unit_addr(addr),
        .dmm_unit_rw(rw), .dmm_unit_dataout(wdata), .dmm_unit_size(size),
        .dmm_unit_done(done1), .dmm_unit_datain(din1), .err_o(err1));

    dmm_line_responder #(.BASE_ADDR(BASE), .LINES(LINES), .LATENCY(15)) u_dut_l15 (
        .clk(clk), .rst(rst), .dmm_unit_strobe(stb2), .dmm_unit_addr(addr),
        .dmm_unit_rw(rw), .dmm_unit_dataout(wdata), .dmm_unit_size(size),
        .dmm_unit_done(done2), .dmm_unit_datain(din2), .err_o(err2));

    // Reference model: one line array and one "last read" value per instance.
    logic [255:0] mem_m  [3][LINES];
    logic [255:0] held_m [3];
    int           lat_of [3] = '{4, 1, 15};

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else passes++;
    endtask

    function automatic logic get_done(input int w);
        return (w == 0) ? done0 : (w == 1) ? done1 : done2;
    endfunction
    function automatic logic get_err(input int w);
        return (w == 0) ? err0 : (w == 1) ? err1 : err2;
    endfunction
    function automatic logic [255:0] get_din(input int w);
        return (w == 0) ? din0 : (w == 1) ? din1 : din2;
    endfunction
    task automatic set_strobe(input int w, input logic v);
        if (w == 0) stb0 = v;
        else if (w == 1) stb1 = v;
        else stb2 = v;
    endtask

    function automatic bit model_in_range(input logic [31:0] a);
        longint unsigned av = 64'(a);
        longint unsigned bv = 64'(BASE);
        return (av >= bv) && (((av - bv) / 32) < LINES);
    endfunction
    function automatic int model_idx(input logic [31:0] a);
        return int'((64'(a) - 64'(BASE)) / 32);
    endfunction

    // One request, strobe held until done; checks latency, err, datain and
    // the one-cycle width of done, then updates the model.
    task automatic do_req(input int w, input bit wr, input logic [31:0] a,
                          input logic [255:0] d, input logic [7:0] sz, input string tag);
        int cyc;
        bit seen;
        bit inr;
        int eff;
        logic [255:0] line;
        @(negedge clk);
        addr = a; rw = wr; wdata = d; size = sz;
        set_strobe(w, 1'b1);
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (get_done(w)) seen = 1;
        end
        inr = model_in_range(a);
        check({tag, " latency"}, cyc, lat_of[w]);
        check({tag, " err"}, get_err(w), !inr);
        if (!wr) held_m[w] = inr ? mem_m[w][model_idx(a)] : '0;
        check({tag, " datain"}, get_din(w), held_m[w]);
        set_strobe(w, 1'b0);
        if (wr && inr) begin
            eff = (sz == 0 || sz >= 32) ? 32 : int'(sz);
            line = mem_m[w][model_idx(a)];
            for (int k = 0; k < eff; k++) line[8*k +: 8] = d[8*k +: 8];
            mem_m[w][model_idx(a)] = line;
        end
        @(negedge clk);
        check({tag, " done pulse"}, get_done(w), 1'b0);
        $display("txn dut%0d %s %s addr=%h size=%0d lat=%0d", w, tag, wr ? "WR" : "RD", a, sz, cyc);
    endtask

    // Strobe held high across several completions: done every LATENCY+1.
    task automatic b2b(input int w, input logic [31:0] a);
        int t [3];
        int n;
        int lim;
        t = '{-1, -1, -1};
        n = 0;
        lim = 4 * (lat_of[w] + 1) + 10;
        @(negedge clk);
        addr = a; rw = 1'b0; wdata = '0; size = '0;
        set_strobe(w, 1'b1);
        for (int c = 1; c <= lim && n < 3; c++) begin
            @(negedge clk);
            if (get_done(w)) begin
                t[n] = c;
                n++;
            end
        end
        set_strobe(w, 1'b0);
        check("b2b first", t[0], lat_of[w]);
        check("b2b gap1", t[1] - t[0], lat_of[w] + 1);
        check("b2b gap2", t[2] - t[1], lat_of[w] + 1);
        repeat (lat_of[w] + 3) @(negedge clk);
        held_m[w] = mem_m[w][model_idx(a)];
        check("b2b datain", get_din(w), held_m[w]);
        $display("txn dut%0d b2b addr=%h done at %0d %0d %0d", w, a, t[0], t[1], t[2]);
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] xval;
        logic [31:0]  ra;
        logic [7:0]   rs;
        int           seen_done;

        for (int w = 0; w < 3; w++) begin
            held_m[w] = '0;
            for (int i = 0; i < LINES; i++) mem_m[w][i] = '0;
        end

        repeat (3) @(negedge clk);
        check("reset done", done0, 1'b0);
        check("reset err", err0, 1'b0);
        check("reset datain", din0, '0);
        rst = 1'b0;
        @(negedge clk);
        check("idle done", done0 | done1 | done2, 1'b0);

        // Write then read within the same line.
        do_req(0, 1, 32'h70000040, {8{32'hDEADBEEF}}, 8'd0, "wr line2");
        do_req(0, 0, 32'h7000005C, '0, 8'd0, "rd line2");
        check("rd line2 value", din0, {8{32'hDEADBEEF}});

        // Partial and oversized writes.
        do_req(0, 1, 32'h70000060, {256{1'b1}}, 8'd0, "fill line3");
        do_req(0, 1, 32'h70000060, '0, 8'd5, "partial line3");
        do_req(0, 0, 32'h70000060, '0, 8'd0, "rd partial");
        check("partial value", din0, {{27{8'hFF}}, {5{8'h00}}});
        xval = rand_line();
        do_req(0, 1, 32'h70000060, xval, 8'd200, "size200 line3");
        do_req(0, 0, 32'h70000060, '0, 8'd0, "rd size200");
        check("size200 value", din0, xval);

        // Out of range on both sides of the store.
        do_req(0, 0, 32'h6FFFFFE0, '0, 8'd0, "oor below");
        do_req(0, 0, 32'h70000800, '0, 8'd0, "oor above");
        do_req(0, 0, 32'h700007E0, '0, 8'd0, "last line");
        do_req(0, 1, 32'h70000800, rand_line(), 8'd0, "oor write");
        for (int i = 0; i < LINES; i++) do_req(0, 0, BASE + 32'(32 * i), '0, 8'd0, "scan");

        // datain hold across a write.
        do_req(0, 1, 32'h70000020, rand_line(), 8'd0, "wr line1");
        do_req(0, 0, 32'h70000020, '0, 8'd0, "rd line1");
        xval = din0;
        do_req(0, 1, 32'h70000040, rand_line(), 8'd0, "wr line2 hold");
        repeat (3) @(negedge clk);
        check("hold after write", din0, xval);

        // Randomised traffic.
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                0: ra = BASE - 32'(32 * $urandom_range(1, 4)) + 32'($urandom_range(0, 31));
                1: ra = BASE + 32'(32 * LINES) + 32'(32 * $urandom_range(0, 3)) + 32'($urandom_range(0, 31));
                default: ra = BASE + 32'(32 * $urandom_range(0, LINES - 1)) + 32'($urandom_range(0, 31));
            endcase
            case ($urandom_range(0, 9))
                0: rs = 8'd0;
                1: rs = 8'd200;
                2: rs = 8'($urandom_range(32, 40));
                default: rs = 8'($urandom_range(1, 31));
            endcase
            do_req(0, 1'($urandom_range(0, 1)), ra, rand_line(), rs, "rand");
        end

        // Latency extremes.
        do_req(1, 1, 32'h70000100, rand_line(), 8'd0, "l1 wr");
        do_req(1, 0, 32'h70000100, '0, 8'd0, "l1 rd");
        do_req(1, 0, 32'h70001000, '0, 8'd0, "l1 oor");
        do_req(2, 1, 32'h70000120, rand_line(), 8'd7, "l15 wr");
        do_req(2, 0, 32'h70000120, '0, 8'd0, "l15 rd");
        b2b(0, 32'h70000040);
        b2b(1, 32'h70000100);
        b2b(2, 32'h70000120);

        // Reset during WAIT aborts a pending write to line 7.
        do_req(0, 1, 32'h700000E0, rand_line(), 8'd0, "pre line7");
        @(negedge clk);
        addr = 32'h700000E0; rw = 1'b1; wdata = rand_line(); size = 8'd0; stb0 = 1'b1;
        @(negedge clk);
        stb0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort done", done0, 1'b0);
        check("abort datain", din0, '0);
        for (int w = 0; w < 3; w++) held_m[w] = '0;
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done0) seen_done++;
        end
        check("abort no done", seen_done, 0);
        do_req(0, 0, 32'h700000E0, '0, 8'd0, "rd line7 after abort");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dmm_line_responder.md
Name: dmm_line_responder

Overview:
- Memory-side responder for the dmm_unit line interface driven by the memory manager.
- Accepts one 256-bit line read or write per request.
- Services it from an internal line store mapped at the heap base, after a programmable latency.
- Returns a single-cycle done pulse.
- Used as the heap backing store in simulation and in FPGA builds without DRAM, and as the reference responder for the manager's master port.

Parameters:
- BASE_ADDR, 32'h70000000: byte address of line 0; matches the allocator heap start.
- LINES, 64: number of 256-bit lines stored; power of two, >= 2.
- LATENCY, 4: cycles from an accepted strobe to done; legal range 1..15.

Ports:
- clk, input, 1: clock; all logic rising-edge.
- rst, input, 1: asynchronous, active-high reset.
- dmm_unit_strobe, input, 1: request valid; sampled only in IDLE.
- dmm_unit_addr, input, 32: request byte address; bits [4:0] ignored (line aligned).
- dmm_unit_rw, input, 1: 1 = write, 0 = read.
- dmm_unit_dataout, input, 256: write data from the initiator.
- dmm_unit_size, input, 8: write byte count from bit 0 upward; 0 = full 32-byte line; values >= 32 treated as 32.
- dmm_unit_done, output, 1: one-cycle completion pulse.
- dmm_unit_datain, output, 256: read data; valid in the done cycle and held until the next read completes.
- err_o, output, 1: one-cycle pulse coincident with done when the address is out of range.

Behaviour:
- Reset values: dmm_unit_done=0, err_o=0, dmm_unit_datain=0, FSM=IDLE, latency counter=0.
- Line-store contents are not cleared by rst; the store is zero-initialised at configuration.
- Request capture (in IDLE, strobe=1):
  - Latch addr, rw, dataout and size.
  - Compute offset = addr - BASE_ADDR as a 32-bit unsigned value.
  - in_range = (addr >= BASE_ADDR) && (offset[31:5] < LINES).
  - index = offset[5+log2(LINES)-1:5].
- FSM:
  - IDLE -> WAIT when strobe=1 and LATENCY>1; the counter loads LATENCY-2.
  - IDLE -> RESP when strobe=1 and LATENCY==1.
  - WAIT: decrement the counter; go to RESP when the counter reaches 0.
  - RESP: assert done for exactly one cycle, then return to IDLE.
- Timing: with the strobe sampled on edge N, done is high in the cycle after edge N+LATENCY-1, so done follows the request edge by exactly LATENCY cycles.
- Strobes seen in WAIT or RESP are ignored, not queued. The initiator holds strobe until done; a strobe still high in the cycle after RESP starts a new request.
- Write commit happens on the RESP edge only:
  - Byte lanes [k] for k < effective size (0 means 32) take dataout bytes; the other lanes keep their value.
  - Byte k = bits [8k+7:8k].
- Read: the line is registered into datain on the edge entering RESP; datain holds that value until a later read completes.
- Out-of-range request (in_range=0):
  - Same latency, and done pulses with err_o=1.
  - No store update.
  - A read drives datain to all zeros.
- Address wrap: if addr < BASE_ADDR, the subtraction underflows and the request is out of range. The last legal line is BASE_ADDR + 32*(LINES-1).
- Reset mid-operation (rst during WAIT or RESP):
  - Abort immediately, return to IDLE, done=0.
  - A pending write is not committed; store contents are otherwise unchanged.
- Simultaneous strobe and done: the strobe is ignored that cycle and accepted in the next (IDLE) cycle.
- Only one request is outstanding at a time; there is no pipelining.

Test Plan:
- Write then read: with LATENCY=4, write addr 32'h70000040 with size 0 and data {8{32'hDEADBEEF}}. Done rises 4 cycles after strobe, err_o=0. A read of 32'h7000005C (same line) returns {8{32'hDEADBEEF}}, with done again at +4.
- Partial write: after line 3 is filled with all-ones, write addr 32'h70000060 with size 5 and data 0. Reading it back gives bytes 0..4 = 8'h00 and bytes 5..31 = 8'hFF. A write with size 200 behaves as a full-line write.
- Out of range: read 32'h6FFFFFE0 and read 32'h70000800 (LINES=64). Both return done+err_o at +4 with datain=0. A write to 32'h70000800 leaves every line unchanged.
- Latency sweep: LATENCY=1 gives done in the cycle after the strobe edge; LATENCY=15 gives done at +15. Strobe held high across done produces back-to-back requests with done every LATENCY+1 cycles.
- Reset mid-write: write line 7 with data A, assert rst for 1 cycle during WAIT, then deassert. No done is seen, FSM returns to IDLE, and a subsequent read of line 7 returns its previous contents.
- Datain hold: read line 1 (value X), then write line 2. datain stays X through and after the write's done.
